mem_port_arbiter: RTL and testbench

- Round-robin arbiter that shares one port of the dual-port ECC memory between NUM_REQ requesters.
- Each requester issues read or write commands with a req/gnt handshake.
- The arbiter drives the memory port through registered outputs, tracks outstanding reads across the memory's fixed read latency, and returns read data tagged with the requester ID.
- Supports locked bursts of up to MAX_BURST beats and counts ECC-corrected read errors reported by the decoder.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
//   arb_state_t : arbiter FSM state (free arbitration / locked burst)
//   rd_entry_t  : one slot of the read-return tracking pipeline
//   id_w()      : width of a requester index for a given requester count
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    // Widest requester ID the tracking entry can carry (up to 256 requesters).
    localparam int RID_MAX_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [RID_MAX_W-1:0] id;
    } rd_entry_t;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority picker.
//   req : request vector
//   ptr : index with highest priority; search proceeds ptr, ptr+1, ... mod N
//   gnt : one-hot grant (zero when nothing requests)
//   idx : encoded index of the granted requester (ptr when nothing requests)
//   any : at least one request present
// N must be a power of two so that the index arithmetic wraps on its own.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = ptr;
        any  = 1'b0;
        cand = '0;
        for (int i = 0; i < N; i++) begin
            cand = ptr + IW'(i);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        if (any) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_REQ requesters.
//   i_req/i_lock/i_we/i_addr/i_din : per-requester command, held until o_gnt
//   o_gnt                          : one-hot combinational grant
//   o_mem_*                        : registered memory port drive
//   i_mem_dout/i_mem_err           : decoded read data and corrected flag
//   o_rvalid/o_rid/o_rdata         : read return, in command order
//   o_err_cnt                      : saturating count of corrected reads
// A locked winner keeps the port for up to MAX_BURST beats; the round-robin
// pointer stays parked at owner+1 during the burst so the next free
// arbitration picks up right after the owner.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int ADDR_WIDTH   = 10,
    parameter int NUM_REQ      = 4,
    parameter int READ_LATENCY = 2,
    parameter int MAX_BURST    = 4,
    parameter int ERR_CNT_W    = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ-1:0]            i_lock,
    input  logic [NUM_REQ-1:0]            i_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
    input  logic [NUM_REQ*WIDTH-1:0]      i_din,
    output logic [NUM_REQ-1:0]            o_gnt,
    output logic                          o_mem_en,
    output logic                          o_mem_we,
    output logic [ADDR_WIDTH-1:0]         o_mem_addr,
    output logic [WIDTH-1:0]              o_mem_din,
    input  logic [WIDTH-1:0]              i_mem_dout,
    input  logic                          i_mem_err,
    output logic                          o_rvalid,
    output logic [$clog2(NUM_REQ)-1:0]    o_rid,
    output logic [WIDTH-1:0]              o_rdata,
    output logic [ERR_CNT_W-1:0]          o_err_cnt
);

    localparam int ID_W   = id_w(NUM_REQ);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);

    // Unpack per-requester address / data buses.
    logic [ADDR_WIDTH-1:0] req_addr [NUM_REQ];
    logic [WIDTH-1:0]      req_din  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_addr[g] = i_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign req_din[g]  = i_din[g*WIDTH +: WIDTH];
    end

    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [BEAT_W-1:0] beats_q, beats_d;
    logic [ID_W-1:0]   ptr_q,   ptr_d;
    logic [ID_W-1:0]   cmd_id_q;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    win;
    logic               accept;
    logic               burst_hold;

    rd_entry_t pipe_q [READ_LATENCY];
    rd_entry_t tail;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_rr (
        .req (i_req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // Owner keeps the port only while it still asks, still locks and has
    // beats left; otherwise free arbitration runs in this same cycle.
    assign burst_hold = (state_q == ARB_BURST) && i_req[owner_q] &&
                        i_lock[owner_q] && (beats_q < BEAT_W'(MAX_BURST));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        beats_d = beats_q;
        ptr_d   = ptr_q;
        gnt     = '0;
        win     = arb_idx;
        accept  = 1'b0;
        if (burst_hold) begin
            gnt[owner_q] = 1'b1;
            win          = owner_q;
            accept       = 1'b1;
            beats_d      = beats_q + 1'b1;
        end else begin
            state_d = ARB_IDLE;
            beats_d = '0;
            if (arb_any) begin
                gnt    = arb_gnt;
                win    = arb_idx;
                accept = 1'b1;
                ptr_d  = arb_idx + 1'b1;
                if (i_lock[arb_idx] && (MAX_BURST > 1)) begin
                    state_d = ARB_BURST;
                    owner_d = arb_idx;
                    beats_d = BEAT_W'(1);
                end
            end
        end
    end

    // Grant is suppressed while reset is asserted so nothing can be
    // handshaken against a register bank that is being cleared.
    assign o_gnt = i_rst_n ? gnt : '0;

    assign tail = pipe_q[READ_LATENCY-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            beats_q    <= '0;
            ptr_q      <= '0;
            cmd_id_q   <= '0;
            o_mem_en   <= 1'b0;
            o_mem_we   <= 1'b0;
            o_mem_addr <= '0;
            o_mem_din  <= '0;
            for (int k = 0; k < READ_LATENCY; k++) pipe_q[k] <= '0;
            o_rvalid   <= 1'b0;
            o_rid      <= '0;
            o_rdata    <= '0;
            o_err_cnt  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            beats_q  <= beats_d;
            ptr_q    <= ptr_d;
            o_mem_en <= accept;
            o_mem_we <= accept & i_we[win];
            if (accept) begin
                o_mem_addr <= req_addr[win];
                o_mem_din  <= req_din[win];
                cmd_id_q   <= win;
            end
            // The issued read enters the tracker the cycle after it is on the
            // port, so the tail lines up with i_mem_dout READ_LATENCY cycles
            // after o_mem_en.
            pipe_q[0].valid <= o_mem_en & ~o_mem_we;
            pipe_q[0].id    <= RID_MAX_W'(cmd_id_q);
            for (int k = 1; k < READ_LATENCY; k++) pipe_q[k] <= pipe_q[k-1];
            o_rvalid <= tail.valid;
            if (tail.valid) begin
                o_rid   <= ID_W'(tail.id);
                o_rdata <= i_mem_dout;
            end
            if (tail.valid && i_mem_err && (o_err_cnt != '1))
                o_err_cnt <= o_err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed requester traffic, a
// behavioural memory with fixed read latency, and a scoreboard of expected
// read returns. A second instance with a 2-bit error counter checks saturation.
module tb_mem_port_arbiter;

    localparam int W  = 8;
    localparam int AW = 10;
    localparam int N  = 4;
    localparam int RL = 2;
    localparam int MB = 4;

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b0;
    logic [N-1:0]    i_req, i_lock, i_we;
    logic [N*AW-1:0] i_addr;
    logic [N*W-1:0]  i_din;
    logic [W-1:0]    i_mem_dout;
    logic            i_mem_err;

    logic [N-1:0]    o_gnt;
    logic            o_mem_en, o_mem_we;
    logic [AW-1:0]   o_mem_addr;
    logic [W-1:0]    o_mem_din;
    logic            o_rvalid;
    logic [1:0]      o_rid;
    logic [W-1:0]    o_rdata;
    logic [15:0]     o_err_cnt;

    logic [N-1:0]    s_gnt;
    logic            s_mem_en, s_mem_we;
    logic [AW-1:0]   s_mem_addr;
    logic [W-1:0]    s_mem_din;
    logic            s_rvalid;
    logic [1:0]      s_rid;
    logic [W-1:0]    s_rdata;
    logic [1:0]      s_err_cnt;

    always #5 i_clk = ~i_clk;

    mem_port_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_REQ(N), .READ_LATENCY(RL),
                       .MAX_BURST(MB), .ERR_CNT_W(16)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_lock(i_lock), .i_we(i_we),
        .i_addr(i_addr), .i_din(i_din), .o_gnt(o_gnt), .o_mem_en(o_mem_en),
        .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_din(o_mem_din),
        .i_mem_dout(i_mem_dout), .i_mem_err(i_mem_err), .o_rvalid(o_rvalid),
        .o_rid(o_rid), .o_rdata(o_rdata), .o_err_cnt(o_err_cnt));

    mem_port_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_REQ(N), .READ_LATENCY(RL),
                       .MAX_BURST(MB), .ERR_CNT_W(2)) dut_sat (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_lock(i_lock), .i_we(i_we),
        .i_addr(i_addr), .i_din(i_din), .o_gnt(s_gnt), .o_mem_en(s_mem_en),
        .o_mem_we(s_mem_we), .o_mem_addr(s_mem_addr), .o_mem_din(s_mem_din),
        .i_mem_dout(i_mem_dout), .i_mem_err(i_mem_err), .o_rvalid(s_rvalid),
        .o_rid(s_rid), .o_rdata(s_rdata), .o_err_cnt(s_err_cnt));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural memory (pmem, driven from the port) and reference contents
    // (rmem, updated at accept time from the requester side).
    logic [W-1:0] pmem [1<<AW];
    logic [W-1:0] rmem [1<<AW];
    bit           perr [1<<AW];

    typedef struct { bit v; logic [W-1:0] d; bit e; } mp_t;
    mp_t mp [RL+1];

    typedef struct { int id; logic [W-1:0] d; int due; bit e; } sb_t;
    sb_t sbq [$];

    int            cyc = 0;
    int            exp_err = 0;
    logic [AW-1:0] last_addr = '0;
    logic [W-1:0]  last_din = '0;

    // One clock: entered just after a negedge with inputs applied, returns at
    // the next negedge.
    task automatic tick(output int gid);
        bit            acc;
        bit            awe;
        logic [AW-1:0] aa;
        logic [W-1:0]  ad;
        sb_t           e;
        acc = 0; awe = 0; aa = '0; ad = '0;
        #1;
        gid = -1;
        for (int i = 0; i < N; i++) if (o_gnt[i]) gid = i;
        chk("gnt_onehot", 32'($countones(o_gnt) <= 1), 1);
        chk("gnt_on_req", 32'(|(o_gnt & ~i_req)), 0);
        acc = (gid >= 0);
        if (acc) begin
            awe = i_we[gid];
            aa  = i_addr[gid*AW +: AW];
            ad  = i_din[gid*W +: W];
            if (awe) rmem[aa] = ad;
            else sbq.push_back('{gid, rmem[aa], cyc + 1 + RL + 1, perr[aa]});
        end
        @(posedge i_clk);
        cyc++;
        #1;
        chk("mem_en", 32'(o_mem_en), 32'(acc));
        chk("mem_we", 32'(o_mem_we), 32'(acc & awe));
        if (acc) begin last_addr = aa; last_din = ad; end
        chk("mem_addr", 32'(o_mem_addr), 32'(last_addr));
        chk("mem_din", 32'(o_mem_din), 32'(last_din));
        if (o_rvalid) begin
            if (sbq.size() == 0) chk("rv_spurious", 1, 0);
            else begin
                e = sbq.pop_front();
                chk("rv_cycle", cyc, e.due);
                chk("rid", 32'(o_rid), e.id);
                chk("rdata", 32'(o_rdata), 32'(e.d));
                if (e.e) exp_err++;
                chk("err_cnt", 32'(o_err_cnt), exp_err);
                chk("err_sat", 32'(s_err_cnt), (exp_err > 3) ? 3 : exp_err);
            end
        end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            chk("rv_missing", 0, 1);
            void'(sbq.pop_front());
        end
        for (int k = RL; k > 0; k--) mp[k] = mp[k-1];
        mp[0].v = o_mem_en & ~o_mem_we;
        mp[0].d = pmem[o_mem_addr];
        mp[0].e = o_mem_en & ~o_mem_we & perr[o_mem_addr];
        if (o_mem_en && o_mem_we) pmem[o_mem_addr] = o_mem_din;
        i_mem_dout = mp[RL].d;
        i_mem_err  = mp[RL].e;
        @(negedge i_clk);
    endtask

    task automatic drain(input int n);
        int g;
        for (int k = 0; k < n; k++) begin
            tick(g);
            chk("idle_gnt", g, -1);
        end
    endtask

    task automatic set_cmd(input int r, input bit we, input int addr, input int din, input bit lk);
        i_req[r] = 1'b1;
        i_we[r]  = we;
        i_lock[r] = lk;
        i_addr[r*AW +: AW] = AW'(addr);
        i_din[r*W +: W]    = W'(din);
    endtask

    task automatic idle_all();
        i_req  = '0;
        i_lock = '0;
    endtask

    // Asserts reset at the current negedge, checks outputs while held with
    // every requester asking, then releases.
    task automatic do_reset();
        i_rst_n = 1'b0;
        sbq.delete();
        exp_err = 0;
        last_addr = '0;
        last_din = '0;
        for (int k = 0; k <= RL; k++) mp[k] = '{0, '0, 0};
        i_mem_err = 1'b0;
        i_req = '1;
        #1;
        chk("rst_gnt", 32'(o_gnt), 0);
        @(posedge i_clk); #1;
        chk("rst_gnt_edge", 32'(o_gnt), 0);
        chk("rst_mem_en", 32'(o_mem_en), 0);
        chk("rst_rvalid", 32'(o_rvalid), 0);
        chk("rst_err_cnt", 32'(o_err_cnt), 0);
        @(negedge i_clk);
        idle_all();
        i_rst_n = 1'b1;
    endtask

    initial begin
        int g;
        i_req = '0; i_lock = '0; i_we = '0; i_addr = '0; i_din = '0;
        i_mem_dout = '0; i_mem_err = 1'b0;
        for (int a = 0; a < (1 << AW); a++) begin pmem[a] = '0; rmem[a] = '0; perr[a] = 0; end
        @(negedge i_clk);
        do_reset();

        // Round-robin with all requesters writing, then all reading back.
        for (int r = 0; r < N; r++) set_cmd(r, 1, 'h100 + r, 'h10 + r, 0);
        for (int k = 0; k < 8; k++) begin tick(g); chk("rr_wr", g, k % N); end
        for (int r = 0; r < N; r++) set_cmd(r, 0, 'h100 + r, 0, 0);
        for (int k = 0; k < 8; k++) begin tick(g); chk("rr_rd", g, k % N); end
        idle_all();
        drain(RL + 2);

        // Read after write from requester 1.
        set_cmd(1, 1, 'h010, 'hA5, 0); tick(g); chk("raw_wr", g, 1);
        set_cmd(1, 0, 'h010, 0, 0);    tick(g); chk("raw_rd", g, 1);
        idle_all();
        drain(RL + 2);

        // Burst up to MAX_BURST, then requester 0 gets the port.
        do_reset();
        set_cmd(2, 0, 'h020, 0, 1); tick(g); chk("bst_1", g, 2);
        set_cmd(0, 1, 'h030, 'h77, 0);
        for (int k = 1; k < MB; k++) begin
            set_cmd(2, 0, 'h020 + k, 0, 1);
            tick(g); chk("bst_n", g, 2);
        end
        tick(g); chk("bst_end", g, 0);
        idle_all();
        drain(RL + 2);

        // Lock dropped after beat 2.
        set_cmd(2, 0, 'h040, 0, 1);    tick(g); chk("drop_1", g, 2);
        set_cmd(0, 1, 'h031, 'h66, 0); tick(g); chk("drop_2", g, 2);
        i_lock[2] = 1'b0;              tick(g); chk("drop_end", g, 0);
        idle_all();
        drain(RL + 2);

        // Corrected-error counting: 3 erroring reads, 1 clean.
        perr['h050] = 1; perr['h051] = 1; perr['h052] = 1;
        for (int k = 0; k < 4; k++) begin
            set_cmd(3, 0, 'h050 + k, 0, 0);
            tick(g); chk("err_rd", g, 3);
        end
        idle_all();
        drain(RL + 2);
        chk("err_total3", 32'(o_err_cnt), 3);
        for (int k = 0; k < 5; k++) begin
            set_cmd(3, 0, 'h050 + (k % 3), 0, 0);
            tick(g); chk("err_rd2", g, 3);
        end
        idle_all();
        drain(RL + 2);
        chk("err_total8", 32'(o_err_cnt), 8);
        chk("err_sat_hold", 32'(s_err_cnt), 3);

        // Reset during beat 2 of a burst with two reads in flight.
        set_cmd(2, 0, 'h060, 0, 1); tick(g); chk("mid_1", g, 2);
        set_cmd(2, 0, 'h061, 0, 1); tick(g); chk("mid_2", g, 2);
        do_reset();
        drain(RL + 3);
        for (int r = 0; r < N; r++) set_cmd(r, 1, 'h070 + r, r, 0);
        tick(g); chk("mid_ptr0", g, 0);
        tick(g); chk("mid_ptr1", g, 1);
        idle_all();
        drain(2);
        chk("sb_empty", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
